// File: rtl/fetch_controller.sv
// -----------------------------------------------------------------------------
// fetch_controller
//
// Instruction fetch front end. It issues one instruction-memory request at a
// time and places each returned word, together with its address, into a
// two-entry FIFO that feeds decode. Branch and jump redirects flush the FIFO
// and move the fetch PC to the new target. If a redirect arrives while a
// request is still outstanding, the controller waits for that response in
// DRAIN and then throws it away.
//
// Optional feature: define FETCH_CTRL_MISALIGN_TRAP_EN to report misaligned
// redirect targets.
//   - Defined: a redirect whose target has bits [1:0] != 0 pulses
//     misalign_trap, flushes the FIFO and parks the controller in HOLD. It
//     stays there until an aligned redirect arrives.
//   - Undefined: the misalign_trap port does not exist, and redirect targets
//     are silently aligned down to a word boundary.
//
// Parameters
//   RESET_PC   first fetch address after reset
//   BUF_DEPTH  instruction buffer entries (only 2 is supported)
//
// Ports
//   clk            clock; all state changes on the rising edge
//   reset          asynchronous active-low reset
//   imem_req       request pending towards instruction memory
//   imem_addr      fetch address, stable while imem_req is high
//   imem_ack       imem_rdata valid for the pending request
//   imem_rdata     instruction word returned by memory
//   redirect_valid branch/jump redirect request
//   redirect_pc    redirect target
//   if_valid       FIFO head holds a valid instruction
//   if_ready       decode accepts the head entry this cycle
//   if_instr       head instruction
//   if_pc          head instruction address
//   misalign_trap  one-cycle pulse on a misaligned redirect (macro builds only)
// -----------------------------------------------------------------------------
module fetch_controller #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
    ,
    output logic        misalign_trap
`endif
);

    localparam logic [1:0] DEPTH = 2'(BUF_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic [31:0] pc_nxt;
    logic [31:0] drain_addr;   // address of the request being drained

    logic [31:0] buf_instr [2];
    logic [31:0] buf_pc    [2];
    logic [1:0]  count;
    logic [1:0]  count_nxt;
    logic        rd_ptr;
    logic        wr_ptr;

    logic        wr_en;
    logic        pop;
    logic        redir_bad;    // redirect target is misaligned
    logic        trap_pend;    // parked in HOLD waiting for an aligned redirect
    logic [31:0] redir_target;

`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
    assign redir_target = redirect_pc;
    assign redir_bad    = redirect_valid & (redirect_pc[1:0] != 2'b00);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            misalign_trap <= 1'b0;
            trap_pend     <= 1'b0;
        end else begin
            misalign_trap <= redir_bad;
            if (redirect_valid)
                trap_pend <= redir_bad;
        end
    end
`else
    // Masking keeps every target bit in the expression while forcing word
    // alignment.
    assign redir_target = redirect_pc & 32'hFFFF_FFFC;
    assign redir_bad    = 1'b0;
    assign trap_pend    = 1'b0;
`endif

    // A redirect flushes the FIFO, so any pop in the same cycle is ignored.
    assign pop       = if_valid & if_ready & ~redirect_valid;
    assign count_nxt = count + {1'b0, wr_en} - {1'b0, pop};

    assign imem_req  = (state == FETCH) || (state == DRAIN);
    assign imem_addr = (state == DRAIN) ? drain_addr : pc;
    assign if_valid  = (count != 2'd0);
    assign if_instr  = buf_instr[rd_ptr];
    assign if_pc     = buf_pc[rd_ptr];

    // Next-state, next-PC and buffer write enable
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        wr_en     = 1'b0;

        unique case (state)
            IDLE: state_nxt = FETCH;
            FETCH: begin
                if (imem_ack && !redirect_valid) begin
                    wr_en  = 1'b1;
                    pc_nxt = pc + 32'd4;
                    // Keep fetching only if a slot stays free after this
                    // cycle's write and pop.
                    if ((count + 2'd1 - {1'b0, pop}) >= DEPTH)
                        state_nxt = HOLD;
                    else
                        state_nxt = FETCH;
                end
            end
            DRAIN: begin
                if (imem_ack)
                    state_nxt = trap_pend ? HOLD : FETCH;
            end
            HOLD: begin
                // Resume as soon as decode frees a slot: either occupancy is
                // already below depth or a pop is happening now.
                if (!trap_pend && ((count < DEPTH) || pop))
                    state_nxt = FETCH;
            end
            default: state_nxt = IDLE;
        endcase

        if (redirect_valid) begin
            pc_nxt = redir_target;
            // An outstanding request must still complete; its data is
            // discarded in DRAIN.
            if (((state == FETCH) || (state == DRAIN)) && !imem_ack)
                state_nxt = DRAIN;
            else
                state_nxt = redir_bad ? HOLD : FETCH;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            drain_addr <= 32'd0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (redirect_valid && (state == FETCH) && !imem_ack)
                drain_addr <= pc;
        end
    end

    // Instruction FIFO
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                buf_instr[i] <= 32'd0;
                buf_pc[i]    <= 32'd0;
            end
        end else if (redirect_valid) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            count <= count_nxt;
            if (wr_en) begin
                buf_instr[wr_ptr] <= imem_rdata;
                buf_pc[wr_ptr]    <= pc;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
module tb_fetch_controller;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    logic        req2;
    logic [31:0] addr2;
    logic        ack2;
    logic [31:0] rdata2;
    logic        redir2;
    logic [31:0] redir_pc2;
    logic        valid2;
    logic        ready2;
    logic [31:0] instr2;
    logic [31:0] pc2;

`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
    logic        misalign_trap;
    logic        trap2;
`endif

    fetch_controller dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc)
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
        ,
        .misalign_trap  (misalign_trap)
`endif
    );

    fetch_controller #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (req2),
        .imem_addr      (addr2),
        .imem_ack       (ack2),
        .imem_rdata     (rdata2),
        .redirect_valid (redir2),
        .redirect_pc    (redir_pc2),
        .if_valid       (valid2),
        .if_ready       (ready2),
        .if_instr       (instr2),
        .if_pc          (pc2)
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
        ,
        .misalign_trap  (trap2)
`endif
    );

    int errors = 0;
    int checks = 0;
    logic [63:0] exp_q[$];   // {instr, pc} expected at the FIFO head on each pop

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Memory contents: word at address a is a ^ 32'h5A5A_0000
    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // Monitor: every accepted head entry is compared with the scoreboard.
    always @(negedge clk) begin
        logic [63:0] e;
        if (reset && if_valid && if_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop: got pc %h instr %h expected none", if_pc, if_instr);
            end else begin
                e = exp_q.pop_front();
                chk("pop_instr", if_instr, e[63:32]);
                chk("pop_pc", if_pc, e[31:0]);
            end
        end
    end

    initial begin
        logic [31:0] a;
        reset = 1'b0;
        imem_ack = 1'b0;
        imem_rdata = 32'd0;
        redirect_valid = 1'b0;
        redirect_pc = 32'd0;
        if_ready = 1'b0;
        ack2 = 1'b0;
        rdata2 = 32'd0;
        redir2 = 1'b0;
        redir_pc2 = 32'd0;
        ready2 = 1'b0;

        repeat (2) tick;
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_if_instr", if_instr, 32'd0);
        chk("rst_if_pc", if_pc, 32'd0);
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
        chk("rst_trap", 32'(misalign_trap), 32'd0);
`endif
        reset = 1'b1;
        chk("idle_req", 32'(imem_req), 32'd0);
        tick;
        chk("fetch_req", 32'(imem_req), 32'd1);
        chk("fetch_addr0", imem_addr, 32'h0);
        chk("wrap_first_addr", addr2, 32'hFFFF_FFF8);

        // Streaming: ack every cycle, decode always ready
        if_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = 32'(i * 4);
            chk("stream_addr", imem_addr, a);
            chk("stream_if_valid", 32'(if_valid), (i == 0) ? 32'd0 : 32'd1);
            imem_ack = 1'b1;
            imem_rdata = mem(imem_addr);
            exp_q.push_back({32'h5A5A_0000 ^ a, a});
            tick;
        end
        imem_ack = 1'b0;
        chk("stream_addr_next", imem_addr, 32'hC);
        tick;
        chk("stream_empty", 32'(if_valid), 32'd0);

        // Reset while a request is pending
        reset = 1'b0;
        #1;
        chk("async_rst_req", 32'(imem_req), 32'd0);
        tick;
        reset = 1'b1;
        chk("restart_idle_req", 32'(imem_req), 32'd0);
        tick;
        chk("restart_addr", imem_addr, 32'h0);

        // Back-pressure: two entries fill the buffer, then HOLD
        if_ready = 1'b0;
        imem_ack = 1'b1;
        imem_rdata = mem(imem_addr);
        tick;
        chk("bp_addr4", imem_addr, 32'h4);
        chk("bp_valid", 32'(if_valid), 32'd1);
        imem_rdata = mem(imem_addr);
        tick;
        imem_ack = 1'b0;
        chk("hold_req", 32'(imem_req), 32'd0);
        chk("hold_head_pc", if_pc, 32'h0);
        chk("hold_head_instr", if_instr, 32'h5A5A_0000);
        tick;
        chk("hold_req_still", 32'(imem_req), 32'd0);
        if_ready = 1'b1;
        exp_q.push_back({32'h5A5A_0000, 32'h0});
        tick;
        if_ready = 1'b0;
        chk("resume_req", 32'(imem_req), 32'd1);
        chk("resume_addr", imem_addr, 32'h8);
        chk("resume_head_pc", if_pc, 32'h4);

        // Redirect while waiting at addr 8: drain, discard, refetch at 0x100
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        tick;
        redirect_valid = 1'b0;
        chk("drain_req", 32'(imem_req), 32'd1);
        chk("drain_addr", imem_addr, 32'h8);
        chk("drain_flushed", 32'(if_valid), 32'd0);
        tick;
        chk("drain_addr_hold", imem_addr, 32'h8);
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick;
        imem_ack = 1'b0;
        chk("post_drain_addr", imem_addr, 32'h100);
        chk("post_drain_req", 32'(imem_req), 32'd1);
        chk("post_drain_empty", 32'(if_valid), 32'd0);
        tick;
        chk("discarded", 32'(if_valid), 32'd0);

        // Redirect coincident with ack and pop
        if_ready = 1'b1;
        imem_ack = 1'b1;
        imem_rdata = mem(imem_addr);
        exp_q.push_back({32'h5A5A_0100, 32'h100});
        tick;
        imem_rdata = mem(imem_addr);
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        tick;
        redirect_valid = 1'b0;
        imem_ack = 1'b0;
        chk("redir_ack_empty", 32'(if_valid), 32'd0);
        chk("redir_ack_addr", imem_addr, 32'h200);
        chk("redir_ack_req", 32'(imem_req), 32'd1);
        imem_ack = 1'b1;
        imem_rdata = mem(imem_addr);
        exp_q.push_back({32'h5A5A_0200, 32'h200});
        tick;
        imem_ack = 1'b0;
        chk("after_redir_pc", if_pc, 32'h200);
        tick;
        chk("after_redir_empty", 32'(if_valid), 32'd0);

`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
        // Misaligned redirect traps and parks in HOLD
        redirect_valid = 1'b1;
        redirect_pc = 32'h102;
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick;
        redirect_valid = 1'b0;
        imem_ack = 1'b0;
        chk("trap_pulse", 32'(misalign_trap), 32'd1);
        chk("trap_req", 32'(imem_req), 32'd0);
        chk("trap_empty", 32'(if_valid), 32'd0);
        tick;
        chk("trap_once", 32'(misalign_trap), 32'd0);
        chk("trap_hold_req", 32'(imem_req), 32'd0);
        tick;
        chk("trap_hold_req2", 32'(imem_req), 32'd0);
        redirect_valid = 1'b1;
        redirect_pc = 32'h104;
        tick;
        redirect_valid = 1'b0;
        chk("trap_exit_req", 32'(imem_req), 32'd1);
        chk("trap_exit_addr", imem_addr, 32'h104);
        chk("trap_exit_pulse", 32'(misalign_trap), 32'd0);
`else
        // Misaligned target is aligned down
        redirect_valid = 1'b1;
        redirect_pc = 32'h302;
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick;
        redirect_valid = 1'b0;
        imem_ack = 1'b0;
        chk("align_addr", imem_addr, 32'h300);
        chk("align_req", 32'(imem_req), 32'd1);
        chk("align_empty", 32'(if_valid), 32'd0);
`endif

        // PC wrap from 32'hFFFF_FFF8
        ready2 = 1'b1;
        chk("wrap_addr0", addr2, 32'hFFFF_FFF8);
        ack2 = 1'b1;
        rdata2 = 32'h1111_1111;
        tick;
        chk("wrap_addr1", addr2, 32'hFFFF_FFFC);
        chk("wrap_valid1", 32'(valid2), 32'd1);
        chk("wrap_pc1", pc2, 32'hFFFF_FFF8);
        chk("wrap_instr1", instr2, 32'h1111_1111);
        rdata2 = 32'h2222_2222;
        tick;
        ack2 = 1'b0;
        chk("wrap_pc2", pc2, 32'hFFFF_FFFC);
        chk("wrap_instr2", instr2, 32'h2222_2222);
        chk("wrap_addr2", addr2, 32'h0);
        chk("wrap_req2", 32'(req2), 32'd1);

        tick;
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 The block SHALL have parameter BUF_DEPTH, default 2, meaning the instruction buffer entries; it is fixed at 2 and other values are unsupported.
REQ-003 The block SHALL have port clk, input, width 1, meaning the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, width 1, meaning the asynchronous active-low reset.
REQ-005 The block SHALL have port imem_req, output, width 1, meaning an instruction memory request is pending.
REQ-006 The block SHALL have port imem_addr, output, width 32, meaning the fetch address, held stable while imem_req is high.
REQ-007 The block SHALL have port imem_ack, input, width 1, meaning imem_rdata is valid for the pending request.
REQ-008 The block SHALL have port imem_rdata, input, width 32, meaning the instruction word returned by memory.
REQ-009 The block SHALL have port redirect_valid, input, width 1, meaning a branch or jump redirect is requested.
REQ-010 The block SHALL have port redirect_pc, input, width 32, meaning the redirect target.
REQ-011 The block SHALL have port if_valid, output, width 1, meaning the buffer head holds a valid instruction.
REQ-012 The block SHALL have port if_ready, input, width 1, meaning decode accepts the head entry this cycle.
REQ-013 The block SHALL have port if_instr, output, width 32, meaning the head instruction.
REQ-014 The block SHALL have port if_pc, output, width 32, meaning the head instruction's address.
REQ-015 The block SHALL have port misalign_trap, output, width 1, meaning a misaligned redirect was seen; this port exists only with the macro in REQ-030.

Function
REQ-016 The FSM SHALL have states IDLE, FETCH, DRAIN and HOLD; only one memory request is outstanding at any time.
REQ-017 In IDLE (entered for one cycle after reset), imem_req SHALL be 0 and the next state SHALL be FETCH with imem_addr = pc.
REQ-018 In FETCH, imem_req SHALL be 1 with imem_addr = pc.
REQ-019 In FETCH, imem_ack SHALL write {imem_rdata, pc} to the buffer tail and set pc <= pc+4, with modulo-2^32 wrap (32'hFFFF_FFFC -> 0).
REQ-020 After the write in REQ-019, the next state SHALL be FETCH if a slot remains free after this cycle's write and pop, otherwise HOLD.
REQ-021 In HOLD, imem_req SHALL be 0, and the FSM SHALL return to FETCH the cycle after occupancy drops below BUF_DEPTH.
REQ-022 Buffer handshake: a pop SHALL occur when if_valid & if_ready; a write and a pop in the same cycle SHALL leave occupancy unchanged.
REQ-023 Buffer ordering SHALL be FIFO, and if_instr and if_pc SHALL come from registered storage.
REQ-024 Fetch latency: if_valid SHALL rise the cycle after the imem_ack that fills an empty buffer.
REQ-025 On redirect_valid, the buffer SHALL be flushed (if_valid = 0 next cycle) and pc SHALL be set to redirect_pc.
REQ-026 If redirect_valid arrives in FETCH without imem_ack, the state SHALL go to DRAIN, keeping imem_req = 1 and the old imem_addr until imem_ack; that response SHALL be discarded, then the state goes to FETCH at the new pc.
REQ-027 Redirect with imem_ack in the same cycle SHALL discard the response and go to FETCH at redirect_pc next cycle; redirect in IDLE/HOLD SHALL go to FETCH; redirect in DRAIN SHALL update pc only.
REQ-028 Redirect wins over a simultaneous pop: the flush takes effect and the pop is ignored.

Reset
REQ-029 While reset = 0, asynchronously: state = IDLE, pc = RESET_PC, buffer empty, if_valid = 0, imem_req = 0, if_instr = 0, if_pc = 0, misalign_trap = 0; deassertion mid-transaction SHALL restart from RESET_PC with no pending request.

Configuration
REQ-030 With FETCH_CTRL_MISALIGN_TRAP_EN defined, a redirect with redirect_pc[1:0] != 0 SHALL assert misalign_trap for one cycle, flush the buffer and enter HOLD until the next aligned redirect; without the macro, the port SHALL be absent and redirect_pc[1:0] SHALL be forced to 0.

Verification
REQ-031 Reset then imem_ack every cycle, with if_ready=1 -> imem_addr 0,4,8,...; if_pc/if_instr in order, if_valid one cycle after each ack.
REQ-032 if_ready=0 with acks -> two entries buffered, state HOLD, imem_req=0; if_ready=1 for one cycle -> FETCH resumes the next cycle at addr 8.
REQ-033 Redirect to 32'h100 while FETCH is waiting at addr 8 -> DRAIN holds addr 8 until ack, data discarded, next imem_addr 32'h100, buffer empty.
REQ-034 Redirect to 32'h200 coincident with imem_ack and pop -> no entry written, buffer empty, next imem_addr 32'h200.
REQ-035 RESET_PC=32'hFFFF_FFF8 with two acks -> if_pc sequence FFFF_FFF8, FFFF_FFFC, then imem_addr 0.
REQ-036 With the macro defined, redirect to 32'h102 -> misalign_trap pulses once, imem_req stays 0 until a redirect to 32'h104.
